// File: rtl/fetch_sequencer.sv
// Program-counter sequencer: owns the PC, start/halt, LUT-resolved branches, call/return stack, run-cycle counter.
// Latency: LutPointer is combinational from BrPtr; ProgCtr/state/counters update one cycle after the inputs.
// Backpressure: Stall freezes PC, stack and state for the cycle while CycleCount keeps counting.
module fetch_sequencer #(
  parameter int PC_W  = 10,
  parameter int PTR_W = 4,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [PC_W-1:0]  StartAddr,
  input  logic             Stall,
  input  logic             Halt,
  input  logic             Jump,
  input  logic             Cond,
  input  logic             Taken,
  input  logic             Call,
  input  logic             Ret,
  input  logic [PTR_W-1:0] BrPtr,
  output logic [PTR_W-1:0] LutPointer,
  input  logic [PC_W-1:0]  AbsAddress,
  output logic [PC_W-1:0]  ProgCtr,
  output logic             Running,
  output logic             Done,
  output logic             Fault,
  output logic [CNT_W-1:0] CycleCount
);

  localparam int IDX_W = $clog2(DEPTH);
  // One extra bit so the pointer can express "full" (sp == DEPTH).
  localparam int SP_W  = IDX_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [PC_W-1:0]  pc, pc_nxt, pc_inc;
  logic [SP_W-1:0]  sp, sp_nxt;
  logic             fault, fault_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             push;
  logic [IDX_W-1:0] push_idx, top_idx;
  logic [PC_W-1:0]  stack [DEPTH];

  assign LutPointer = BrPtr;
  assign ProgCtr    = pc;
  assign Fault      = fault;
  assign CycleCount = cnt;
  assign Running    = (state == RUN);
  assign Done       = (state == DONE);

  // PC wraps naturally at 2^PC_W; return address and sequential step share this.
  assign pc_inc   = pc + PC_W'(1);
  assign push_idx = sp[IDX_W-1:0];
  assign top_idx  = IDX_W'(sp - SP_W'(1));

  // State, PC, stack pointer, fault and counter registers; reset dominates everything.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      pc    <= '0;
      sp    <= '0;
      fault <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      sp    <= sp_nxt;
      fault <= fault_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Return-stack storage; contents are don't-care after reset so no reset term.
  always_ff @(posedge Clk) begin
    if (push && !Reset) begin
      stack[push_idx] <= pc_inc;
    end
  end

  // Next-state and datapath decode with Halt > Ret > Call > Jump > sequential priority.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    sp_nxt    = sp;
    fault_nxt = fault;
    cnt_nxt   = cnt;
    push      = 1'b0;

    case (state)
      IDLE, DONE: begin
        // DONE re-launch behaves exactly like a launch from IDLE.
        if (Start) begin
          pc_nxt    = StartAddr;
          cnt_nxt   = '0;
          fault_nxt = 1'b0;
          sp_nxt    = '0;
          state_nxt = RUN;
        end
      end

      RUN: begin
        // Counter runs through stalls and saturates rather than wrapping.
        if (cnt != '1) begin
          cnt_nxt = cnt + CNT_W'(1);
        end
        if (!Stall) begin
          if (Halt) begin
            state_nxt = DONE;
          end else if (Ret) begin
            if (sp == '0) begin
              fault_nxt = 1'b1;
              state_nxt = DONE;
            end else begin
              sp_nxt = sp - SP_W'(1);
              pc_nxt = stack[top_idx];
            end
          end else if (Call) begin
            if (sp == SP_W'(DEPTH)) begin
              fault_nxt = 1'b1;
              state_nxt = DONE;
            end else begin
              push   = 1'b1;
              sp_nxt = sp + SP_W'(1);
              pc_nxt = AbsAddress;
            end
          end else if (Jump && (!Cond || Taken)) begin
            pc_nxt = AbsAddress;
          end else begin
            pc_nxt = pc_inc;
          end
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Program-counter sequencer for the core. It owns the PC, issues start and halt, and resolves absolute branch targets by driving the branch LUT's LutPointer and consuming its absaddress. It also keeps a small call/return stack and a run-cycle counter. It sits between the instruction decoder, the instruction ROM address port and the branch LUT.

Parameters:
PC_W, 10, PC and branch-target width (matches LUT absaddress).
PTR_W, 4, LUT pointer width.
DEPTH, 4, return-stack entries (power of 2, at least 2).
CNT_W, 16, cycle-counter width.

Ports:
Clk  in  1  clock, rising edge
Reset  in  1  synchronous, active-high
Start  in  1  pulse; launch program at StartAddr
StartAddr  in  PC_W  program entry address
Stall  in  1  freeze PC and stack this cycle
Halt  in  1  decoded halt instruction
Jump  in  1  decoded branch instruction
Cond  in  1  1 = conditional branch, 0 = unconditional
Taken  in  1  branch condition from ALU flags
Call  in  1  decoded call (always taken, pushes return address)
Ret  in  1  decoded return
BrPtr  in  PTR_W  pointer field of branch/call instruction
LutPointer  out  PTR_W  to LUT; combinational copy of BrPtr
AbsAddress  in  PC_W  from LUT absaddress
ProgCtr  out  PC_W  registered PC to instruction ROM
Running  out  1  high in RUN
Done  out  1  high in DONE
Fault  out  1  sticky stack overflow/underflow flag
CycleCount  out  CNT_W  RUN cycles since last Start

Behaviour:
- Reset values: ProgCtr=0, state=IDLE, Running=0, Done=0, Fault=0, CycleCount=0, stack pointer=0. Stack contents are don't-care.
- Reset mid-operation returns every output to its reset value on the next edge. Reset beats all other inputs.
- LutPointer = BrPtr with zero latency. AbsAddress is sampled in the same cycle as Jump or Call.
- States: IDLE, RUN, DONE. Running and Done are decoded from the state register.
- IDLE: PC held. Start -> PC<=StartAddr, CycleCount<=0, Fault<=0, sp<=0, state RUN.
- RUN: CycleCount increments each cycle, saturating at all-ones. Stall counts too. Start is ignored.
- RUN with Stall=1: PC, sp and state are unchanged; Halt/Jump/Call/Ret are ignored.
- RUN with Stall=0, priority Halt > Ret > Call > Jump > sequential:
  - Halt -> state DONE, PC held.
  - Ret with sp=0 -> Fault<=1, state DONE (underflow).
  - Ret otherwise -> sp<=sp-1, PC<=stack[sp-1].
  - Call with sp=DEPTH -> Fault<=1, state DONE (overflow).
  - Call otherwise -> stack[sp]<=PC+1 (mod 2^PC_W), sp<=sp+1, PC<=AbsAddress.
  - Jump with (Cond=0 or Taken=1) -> PC<=AbsAddress.
  - Jump not taken, or no control input -> PC<=PC+1.
- PC arithmetic is modulo 2^PC_W: 1023+1 wraps to 0. Not a fault.
- Simultaneous Halt and Call/Jump: Halt wins and the stack is untouched.
- DONE: PC, CycleCount and Fault held. Start -> same actions as from IDLE (re-launch).
- Start and Reset together: Reset wins.

Test Plan:
- Reset, then Start with StartAddr=14, 5 idle cycles -> ProgCtr 14,15,16,17,18,19; Running=1; CycleCount=5.
- RUN at PC=20, Jump=1, Cond=0, BrPtr=2, LUT returns 44 -> LutPointer=2 same cycle; next ProgCtr=44. Cond=1, Taken=0 -> ProgCtr=21.
- Call at PC=30 with BrPtr=0 (LUT 14), then Ret at PC=16 -> ProgCtr 14 then 31; sp returns to 0. Five nested Calls with DEPTH=4 -> Fault=1, Done=1, ProgCtr frozen.
- Stall held 3 cycles while Jump asserted -> ProgCtr unchanged and CycleCount +3. Release Stall with Jump still asserted -> branch taken. Halt+Jump same cycle -> DONE, PC held.
- StartAddr=1022, run -> 1022, 1023, 0 with no Fault. Assert Reset mid-RUN -> next cycle all outputs at reset values. Start from DONE -> CycleCount=0, Fault=0, new PC.
